// File: rtl/debug_slave_dr_engine.sv
// Single-clock debug-slave data-register engine: captures per-instruction status,
// shifts it serially, validates scan length on update and decodes IR into action pulses.
module debug_slave_dr_engine #(
  parameter int IR_W   = 2,
  parameter int DR_W   = 38,
  parameter int CNT_W  = 7,
  localparam int NUM_CH = 2**IR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IR_W-1:0]        ir_in,
  input  logic                   vs_uir,
  input  logic                   vs_cdr,
  input  logic                   vs_sdr,
  input  logic                   vs_udr,
  input  logic                   tdi,
  output logic                   tdo,
  input  logic [NUM_CH*DR_W-1:0] capture_data,
  output logic [DR_W-1:0]        jdo,
  output logic [1:0]             ir_out,
  output logic [NUM_CH-1:0]      take_action,
  output logic [NUM_CH-1:0]      take_no_action,
  output logic                   scan_err
);

  // state | meaning
  // IDLE  | no scan open; shift and update strobes are ignored
  // CAPT  | status word captured, no bits shifted yet
  // SHIFT | at least one bit shifted since the last capture
  typedef enum logic [1:0] {IDLE, CAPT, SHIFT} state_t;

  state_t            state, state_nxt;
  logic              capture, do_shift, do_update;
  logic              scan_good;
  logic [DR_W-1:0]   sr;
  logic [CNT_W-1:0]  shift_cnt;
  logic [IR_W-1:0]   ir_reg;
  logic              err_sticky;
  logic              pend;
  logic [IR_W-1:0]   pend_ch;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    do_shift  = 1'b0;
    do_update = 1'b0;
    case (state)
      IDLE: begin
        if (vs_cdr) begin
          capture   = 1'b1;
          state_nxt = CAPT;
        end
      end
      CAPT, SHIFT: begin
        if (vs_cdr) begin
          capture   = 1'b1;
          state_nxt = CAPT;
        end else if (vs_udr) begin
          do_update = 1'b1;
          state_nxt = IDLE;
        end else if (vs_sdr) begin
          do_shift  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign scan_good = (shift_cnt == CNT_W'(DR_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      sr             <= '0;
      jdo            <= '0;
      ir_reg         <= '0;
      shift_cnt      <= '0;
      err_sticky     <= 1'b0;
      pend           <= 1'b0;
      pend_ch        <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      scan_err       <= 1'b0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      scan_err       <= 1'b0;
      pend           <= 1'b0;

      // jdo was loaded on the previous edge, so its action bit is valid here
      if (pend) begin
        if (jdo[DR_W-1]) take_action    <= NUM_CH'(1) << pend_ch;
        else             take_no_action <= NUM_CH'(1) << pend_ch;
      end

      if (capture) begin
        sr        <= capture_data[int'(ir_reg)*DR_W +: DR_W];
        shift_cnt <= '0;
      end else if (do_shift) begin
        sr <= {tdi, sr[DR_W-1:1]};
        if (shift_cnt != CNT_W'(DR_W+1)) shift_cnt <= shift_cnt + CNT_W'(1);
      end

      if (do_update) begin
        if (scan_good) begin
          jdo     <= sr;
          pend    <= 1'b1;
          pend_ch <= ir_reg;
        end else begin
          scan_err <= 1'b1;
        end
      end

      if (vs_uir) ir_reg <= ir_in;

      if (do_update && !scan_good) err_sticky <= 1'b1;
      else if (vs_uir)             err_sticky <= 1'b0;
    end
  end

  assign tdo    = sr[0];
  assign ir_out = {err_sticky, (state != IDLE)};

endmodule

// File: tb/tb_debug_slave_dr_engine.sv
// Randomised bench for debug_slave_dr_engine against a bit-queue scan model,
// with a few directed scenarios carrying hand-computed constants.
module tb_debug_slave_dr_engine;
  localparam int IR_W = 2;
  localparam int DR_W = 38;
  localparam int CNT_W = 7;
  localparam int NUM_CH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset = 1'b0;
  logic [IR_W-1:0]        ir_in = '0;
  logic                   vs_uir = 0, vs_cdr = 0, vs_sdr = 0, vs_udr = 0, tdi = 0;
  logic                   tdo;
  logic [NUM_CH*DR_W-1:0] capture_data = '0;
  logic [DR_W-1:0]        jdo;
  logic [1:0]             ir_out;
  logic [NUM_CH-1:0]      take_action, take_no_action;
  logic                   scan_err;

  debug_slave_dr_engine #(.IR_W(IR_W), .DR_W(DR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
    .vs_sdr(vs_sdr), .vs_udr(vs_udr), .tdi(tdi), .tdo(tdo),
    .capture_data(capture_data), .jdo(jdo), .ir_out(ir_out),
    .take_action(take_action), .take_no_action(take_no_action), .scan_err(scan_err)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference model: scan register as a bit queue, front = bit nearest tdo
  bit              mq[$];
  int              m_cnt;
  bit              m_open;
  logic [DR_W-1:0] m_jdo;
  logic [IR_W-1:0] m_ir;
  bit              m_sticky;
  bit              m_pend, m_pend_act;
  int              m_pend_ch;
  logic [NUM_CH-1:0] e_ta, e_tna;
  bit              e_err;

  function automatic logic [DR_W-1:0] pack_q();
    logic [DR_W-1:0] v;
    for (int i = 0; i < DR_W; i++) v[i] = mq[i];
    return v;
  endfunction

  task automatic model_edge();
    logic [DR_W-1:0] w;
    bit set_err;
    if (reset) begin
      mq.delete();
      for (int i = 0; i < DR_W; i++) mq.push_back(1'b0);
      m_cnt = 0; m_open = 0; m_jdo = '0; m_ir = '0; m_sticky = 0;
      m_pend = 0; e_ta = '0; e_tna = '0; e_err = 0;
      return;
    end
    e_ta = '0; e_tna = '0; e_err = 0; set_err = 0;
    if (m_pend) begin
      if (m_pend_act) e_ta[m_pend_ch] = 1'b1;
      else            e_tna[m_pend_ch] = 1'b1;
      m_pend = 0;
    end
    if (vs_cdr) begin
      w = capture_data[int'(m_ir)*DR_W +: DR_W];
      mq.delete();
      for (int i = 0; i < DR_W; i++) mq.push_back(w[i]);
      m_cnt = 0; m_open = 1;
    end else if (m_open && vs_udr) begin
      m_open = 0;
      if (m_cnt == DR_W) begin
        m_jdo = pack_q();
        m_pend = 1; m_pend_ch = int'(m_ir); m_pend_act = m_jdo[DR_W-1];
      end else begin
        e_err = 1; set_err = 1;
      end
    end else if (m_open && vs_sdr) begin
      void'(mq.pop_front());
      mq.push_back(tdi);
      m_cnt++;
    end
    if (set_err) m_sticky = 1;
    else if (vs_uir) m_sticky = 0;
    if (vs_uir) m_ir = ir_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("tdo", 64'(tdo), 64'(mq[0]));
    chk("jdo", 64'(jdo), 64'(m_jdo));
    chk("ir_out", 64'(ir_out), 64'({m_sticky, m_open}));
    chk("take_action", 64'(take_action), 64'(e_ta));
    chk("take_no_action", 64'(take_no_action), 64'(e_tna));
    chk("scan_err", 64'(scan_err), 64'(e_err));
  endtask

  task automatic step(input bit uir, input bit cdr, input bit sdr, input bit udr,
                      input bit d, input logic [IR_W-1:0] ir, input bit rst);
    vs_uir = uir; vs_cdr = cdr; vs_sdr = sdr; vs_udr = udr; tdi = d; ir_in = ir; reset = rst;
    tick();
    vs_uir = 0; vs_cdr = 0; vs_sdr = 0; vs_udr = 0; tdi = 0; reset = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, ir_in, 0);
  endtask

  task automatic rand_capture();
    for (int k = 0; k < NUM_CH; k++)
      capture_data[k*DR_W +: DR_W] = DR_W'({$urandom, $urandom});
  endtask

  task automatic shift_word(input logic [DR_W-1:0] v, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0, v[i % DR_W], ir_in, 0);
  endtask

  initial begin
    logic [DR_W-1:0] word_a, word_b;
    logic [7:0] ef;
    int n;

    step(0, 0, 0, 0, 0, 0, 1);
    chk("reset_jdo", 64'(jdo), 64'd0);
    chk("reset_ir_out", 64'(ir_out), 64'd0);

    // good action scan on channel 2
    rand_capture();
    capture_data[2*DR_W +: DR_W] = 38'h0_DEAD_BEEF;
    word_a = 38'h20_1234_5678;
    ef = 8'hEF;
    step(1, 0, 0, 0, 0, 2'd2, 0);
    step(0, 1, 0, 0, 0, 2'd2, 0);
    for (int i = 0; i < DR_W; i++) begin
      if (i < 8) chk("tdo_stream", 64'(tdo), 64'(ef[i]));
      step(0, 0, 1, 0, word_a[i], 2'd2, 0);
    end
    step(0, 0, 0, 1, 0, 2'd2, 0);
    chk("good_jdo", 64'(jdo), 64'(word_a));
    idle(1);
    chk("good_action", 64'(take_action), 64'h4);
    idle(1);
    chk("action_once", 64'(take_action), 64'h0);

    // no-action scan on channel 1
    word_b = 38'h0A_AAAA_AAAA;
    step(1, 0, 0, 0, 0, 2'd1, 0);
    step(0, 1, 0, 0, 0, 2'd1, 0);
    shift_word(word_b, DR_W);
    step(0, 0, 0, 1, 0, 2'd1, 0);
    idle(1);
    chk("no_action", 64'(take_no_action), 64'h2);
    chk("no_action_ta", 64'(take_action), 64'h0);

    // short and long scans
    step(0, 1, 0, 0, 0, 2'd1, 0);
    shift_word(word_a, 37);
    step(0, 0, 0, 1, 0, 2'd1, 0);
    chk("short_err", 64'(scan_err), 64'd1);
    chk("short_ir_out", 64'(ir_out), 64'h2);
    chk("short_jdo", 64'(jdo), 64'(word_b));
    step(0, 1, 0, 0, 0, 2'd1, 0);
    shift_word(word_a, 45);
    step(0, 0, 0, 1, 0, 2'd1, 0);
    chk("long_err", 64'(scan_err), 64'd1);
    idle(2);
    step(1, 0, 0, 0, 0, 2'd0, 0);
    chk("uir_clears", 64'(ir_out), 64'h0);

    // zero-shift update, cdr/udr collision, uir with a good udr
    step(0, 1, 0, 0, 0, 2'd0, 0);
    step(0, 0, 0, 1, 0, 2'd0, 0);
    chk("zero_shift_err", 64'(scan_err), 64'd1);
    step(0, 1, 0, 0, 0, 2'd0, 0);
    shift_word(word_a, DR_W);
    step(0, 1, 0, 1, 0, 2'd0, 0);
    chk("cdr_wins_busy", 64'(ir_out[0]), 64'd1);
    shift_word(word_a, DR_W);
    step(1, 0, 0, 1, 0, 2'd3, 0);
    idle(1);
    chk("old_ir_decode", 64'(take_action), 64'h1);

    // reset mid-scan
    step(0, 1, 0, 0, 0, 2'd3, 0);
    shift_word(word_a, 20);
    step(0, 0, 0, 0, 0, 2'd3, 1);
    step(0, 0, 0, 1, 0, 2'd3, 0);
    chk("rst_no_err", 64'(scan_err), 64'd0);
    chk("rst_jdo0", 64'(jdo), 64'd0);
    idle(1);
    chk("rst_no_pulse", 64'(take_action | take_no_action), 64'd0);

    // randomised transactions
    for (int t = 0; t < 120; t++) begin
      rand_capture();
      if ($urandom_range(0, 3) == 0) step(1, 0, 0, 0, 0, 2'($urandom), 0);
      if ($urandom_range(0, 5) == 0) step(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 1, ir_in, 0);
      step(0, 1, 0, 0, 0, ir_in, 0);
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 45)) : DR_W;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0) idle(1);
        if ($urandom_range(0, 80) == 0) step(0, 1, 0, 0, 0, ir_in, 0);
        if ($urandom_range(0, 150) == 0) step(0, 0, 0, 0, 0, ir_in, 1);
        step(0, 0, 1, 0, $urandom_range(0, 1), ir_in, 0);
      end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1), 1,
           $urandom_range(0, 1), 2'($urandom), 0);
      idle($urandom_range(0, 3));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/debug_slave_dr_engine.md
Name: debug_slave_dr_engine

Overview:
- Parametrised, single-clock successor to the debug-slave sysclk/tck pair.
- Captures per-instruction status, shifts it serially, and validates scan length on update.
- On a good update, decodes the latched IR into one-cycle take_action / take_no_action pulses, one pair per instruction code.
- Sits between the virtual-JTAG strobe synchroniser (all strobes already in the clk domain) and the CPU debug core.

Parameters:
- IR_W, 2, instruction register width; NUM_CH = 2**IR_W channels.
- DR_W, 38, data register width; bit DR_W-1 is the action bit.
- CNT_W, 7, shift counter width; must satisfy 2**CNT_W > DR_W+1.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- ir_in  in  IR_W  instruction code; sampled on vs_uir.
- vs_uir  in  1  update-IR strobe, one cycle.
- vs_cdr  in  1  capture-DR strobe, one cycle.
- vs_sdr  in  1  shift-DR enable; one bit per asserted cycle.
- vs_udr  in  1  update-DR strobe, one cycle.
- tdi  in  1  serial in.
- tdo  out  1  serial out, equal to sr[0].
- capture_data  in  NUM_CH*DR_W  per-channel capture word; channel k occupies bits [k*DR_W +: DR_W].
- jdo  out  DR_W  last validated DR contents.
- ir_out  out  2  status: {scan_err_sticky, busy}.
- take_action  out  NUM_CH  one-hot pulse.
- take_no_action  out  NUM_CH  one-hot pulse.
- scan_err  out  1  one-cycle pulse on a bad-length update.

Behaviour:
Reset (synchronous, reset=1 at a rising edge):
- sr=0, jdo=0, ir_reg=0, shift_cnt=0, state=IDLE.
- take_action=0, take_no_action=0, scan_err=0, scan_err_sticky=0.
- Reset mid-scan discards everything; no pulse follows.

State machine (IDLE, CAPT, SHIFT):
- IDLE:
  - vs_cdr: sr <= capture_data channel ir_reg; shift_cnt <= 0; go to CAPT.
  - vs_sdr or vs_udr: ignored.
- CAPT or SHIFT:
  - vs_sdr: sr <= {tdi, sr[DR_W-1:1]}; shift_cnt increments, saturating at DR_W+1; go to SHIFT.
  - vs_udr: evaluated as below; go to IDLE.
  - vs_cdr: recaptures, clears shift_cnt, goes to CAPT.
- busy = (state != IDLE).

Update evaluation on vs_udr:
- shift_cnt == DR_W: the scan is good.
  - jdo <= sr on the next edge.
  - The cycle after that (udr+2), exactly one pulse for one cycle:
    - take_action[ir_reg] if the action bit jdo[DR_W-1] is 1;
    - take_no_action[ir_reg] otherwise.
- shift_cnt != DR_W: the scan is bad (includes 0 shifts and overlength).
  - jdo holds its value.
  - No action pulse.
  - scan_err pulses at udr+1; scan_err_sticky sets.
- Udr from CAPT with no shifts is a bad scan.

Instruction register and sticky error:
- vs_uir: ir_reg <= ir_in.
- vs_uir also clears scan_err_sticky.
- ir_reg changes affect only later captures and decodes. A pulse already scheduled uses the ir_reg latched at udr.

Simultaneous strobes:
- Priority is vs_cdr > vs_udr > vs_sdr.
- vs_uir is independent and may coincide with any of them.
- uir with udr in the same cycle: decode uses the old ir_reg.
- uir with bad-scan udr in the same cycle: the sticky stays set (set wins).

Outputs:
- take_action, take_no_action and scan_err are registered and never assert together.
- tdo is registered, coming from sr.

Test Plan:
- Good action scan: reset; uir ir_in=2; cdr with channel 2 = 38'h0_DEAD_BEEF; 38 sdr cycles with tdi pattern giving sr=38'h20_1234_5678; udr -> tdo stream starts 1,1,1,1,0,1,1,1 (EF LSB-first); jdo=38'h20_1234_5678 at udr+1; take_action=4'b0100 for one cycle at udr+2.
- No-action scan: ir=1; shift in 38'h0A_AAAA_AAAA -> take_no_action=4'b0010 for one cycle; take_action stays 0.
- Short and long scans: 37 shifts then udr -> scan_err pulse, ir_out=2'b10, jdo unchanged, no action pulse. Repeat with 45 shifts -> same result. Then uir -> ir_out=2'b00.
- Udr with no shifts (cdr then immediately udr) -> scan_err; no pulse.
- Priority: cdr and udr in the same cycle -> recapture, no pulse. uir ir_in=3 with udr in the same cycle on a good scan at ir=0 -> pulse on bit 0; the next capture uses channel 3.
- Reset at shift 20 of 38, then udr -> no pulse, no scan_err, jdo=0, ir_out=0.
